// File: rtl/ram_initiator.sv
// Drives the async cs/we/oe RAM pins from a valid/ready request; response after SETUP+STROBE+HOLD+1 cycles.
// req_ready only in IDLE; the response is held in RESP until rsp_ready, stalling new requests.
module ram_initiator #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    localparam int MAX_PHASE = (SETUP_CYCLES > STROBE_CYCLES)
                             ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                             : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int CW = $clog2(MAX_PHASE) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  op_we, op_we_d;
    logic                  req_ready_d, rsp_valid_d, rsp_we_d;
    logic                  cs_d, we_d, oe_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
    logic                  last;

    assign last = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_we       <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_rdata   <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            op_we       <= op_we_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_we      <= rsp_we_d;
            rsp_rdata   <= rdata_d;
            mem_address <= addr_d;
            mem_data_in <= wdata_d;
            mem_cs      <= cs_d;
            mem_we      <= we_d;
            mem_oe      <= oe_d;
        end
    end

    // Every output is computed one cycle ahead so the pins come straight from flops.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        op_we_d     = op_we;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_we_d    = rsp_we;
        rdata_d     = rsp_rdata;
        addr_d      = mem_address;
        wdata_d     = mem_data_in;
        cs_d        = mem_cs;
        we_d        = mem_we;
        oe_d        = mem_oe;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_d     = SETUP;
                    cnt_d       = CW'(SETUP_CYCLES - 1);
                    op_we_d     = req_we;
                    req_ready_d = 1'b0;
                    addr_d      = req_addr;
                    wdata_d     = req_we ? req_wdata : '0;
                    cs_d        = 1'b1;
                end
            end
            SETUP: begin
                if (last) begin
                    state_d = STROBE;
                    cnt_d   = CW'(STROBE_CYCLES - 1);
                    we_d    = op_we;
                    oe_d    = !op_we;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    we_d    = 1'b0;
                    oe_d    = 1'b0;
                    if (!op_we) begin
                        rdata_d = mem_data_out;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (last) begin
                    state_d     = RESP;
                    cs_d        = 1'b0;
                    addr_d      = '0;
                    wdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = op_we;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
